// File: rtl/mine_placer.sv
// mine_placer: board-setup stage for the 5x5 minesweeper board RAM.
// On an accepted start it clears every playable cell to CLEAR_CODE and then
// places NUM_MINES mines at distinct pseudo-random cells. Candidates come from
// a 16-bit Fibonacci LFSR.
// Optional feature macro: SAFE_FIRST_CELL_EN adds a safe_cell input. That cell
// is never chosen as a mine, so the first clicked cell is always safe.
module mine_placer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NUM_CELLS     = 25,
  parameter int CELL_BITS     = 5,
  parameter int NUM_MINES     = 5,
  parameter int MINE_CODE     = 10,
  parameter int CLEAR_CODE    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              seed,
`ifdef SAFE_FIRST_CELL_EN
  input  logic [CELL_BITS-1:0]     safe_cell,
`endif
  input  logic [DATA_WIDTH-1:0]    mem_dataOut,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  output logic                     busy,
  output logic                     done,
  output logic [CELL_BITS:0]       mines
);

  localparam logic [15:0]              LFSR_DEFAULT = 16'hACE1;
  localparam logic [DATA_WIDTH-1:0]    MINE_WORD    = DATA_WIDTH'(MINE_CODE);
  localparam logic [DATA_WIDTH-1:0]    CLEAR_WORD   = DATA_WIDTH'(CLEAR_CODE);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX     = ADDRESS_WIDTH'(NUM_CELLS - 1);
  localparam logic [CELL_BITS:0]       CELLS_LIM    = (CELL_BITS + 1)'(NUM_CELLS);
  localparam logic [CELL_BITS:0]       MINES_TARGET = (CELL_BITS + 1)'(NUM_MINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PICK,
    S_PROBE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   state;
  logic [15:0]              lfsr;
  logic [15:0]              lfsr_next;
  logic [15:0]              seed_eff;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [CELL_BITS-1:0]     cand;
  logic                     cand_in_range;
  logic                     cand_ok;
  logic                     mine_hit;
  logic                     last_mine;

`ifdef SAFE_FIRST_CELL_EN
  logic [CELL_BITS-1:0]     safe_q;
`endif

  // Candidate generation: next LFSR state, low bits as the cell index,
  // eligibility test, and the duplicate-mine check on the RAM read data.
  always_comb begin
    lfsr_next     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    seed_eff      = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    cand          = lfsr[CELL_BITS-1:0];
    cand_in_range = ({1'b0, cand} < CELLS_LIM);
`ifdef SAFE_FIRST_CELL_EN
    cand_ok       = cand_in_range && (cand != safe_q);
`else
    cand_ok       = cand_in_range;
`endif
    mine_hit      = (mem_dataOut == MINE_WORD);
    last_mine     = ((mines + 1'b1) == MINES_TARGET);
  end

  // Main controller: clear sweep, then pick/probe/write loop until all mines are placed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_DEFAULT;
      idx        <= '0;
      mem_wEn    <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mines      <= '0;
`ifdef SAFE_FIRST_CELL_EN
      safe_q     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          mem_wEn <= 1'b0;
          if (start) begin
            lfsr       <= seed_eff;
            mines      <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            idx        <= '0;
            mem_wEn    <= 1'b1;
            mem_addr   <= '0;
            mem_dataIn <= CLEAR_WORD;
`ifdef SAFE_FIRST_CELL_EN
            safe_q     <= safe_cell;
`endif
            state      <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (idx == LAST_IDX) begin
            mem_wEn <= 1'b0;
            state   <= S_PICK;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= idx + 1'b1;
          end
        end

        S_PICK: begin
          mem_wEn <= 1'b0;
          lfsr    <= lfsr_next;
          if (cand_ok) begin
            mem_addr <= ADDRESS_WIDTH'(cand);
            state    <= S_PROBE;
          end
        end

        S_PROBE: begin
          if (mine_hit) begin
            state <= S_PICK;
          end else begin
            mem_wEn    <= 1'b1;
            mem_dataIn <= MINE_WORD;
            state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          mem_wEn <= 1'b0;
          mines   <= mines + 1'b1;
          if (last_mine) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_PICK;
          end
        end

        default: begin
          mem_wEn <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: directed bench for mine_placer with a behavioural board RAM,
// a reference placement model and a write scoreboard.
// Build with SAFE_FIRST_CELL_EN defined to also exercise the safe-cell exclusion.
module tb_mine_placer;

  localparam int CELLS = 25;
`ifdef SAFE_FIRST_CELL_EN
  localparam int MINES = 24;
`else
  localparam int MINES = 5;
`endif
  localparam int MINE  = 10;
  localparam int LIMIT = 3000;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] seed;
`ifdef SAFE_FIRST_CELL_EN
  logic [4:0]  safe_cell;
`endif
  logic [31:0] mem_dataOut;
  logic        mem_wEn;
  logic [9:0]  mem_addr;
  logic [31:0] mem_dataIn;
  logic        busy;
  logic        done;
  logic [5:0]  mines;

  logic [31:0] ram [0:1023];
  logic        bd_en;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  wr_t         exp_q[$];
  int          model_board [0:CELLS-1];
  int          checks = 0;
  int          fails  = 0;

  mine_placer #(.NUM_MINES(MINES)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
`ifdef SAFE_FIRST_CELL_EN
    .safe_cell   (safe_cell),
`endif
    .mem_dataOut (mem_dataOut),
    .mem_wEn     (mem_wEn),
    .mem_addr    (mem_addr),
    .mem_dataIn  (mem_dataIn),
    .busy        (busy),
    .done        (done),
    .mines       (mines)
  );

  always #5 clk = ~clk;

  // Board RAM model: negedge write port, combinational read, plus a backdoor write.
  always @(negedge clk) begin
    if (bd_en)
      ram[bd_addr] <= bd_data;
    else if (mem_wEn)
      ram[mem_addr] <= mem_dataIn;
  end

  assign mem_dataOut = ram[mem_addr];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference placement: fills the expected write queue and returns the cycle count to done.
  task automatic buildModel(input logic [15:0] s, input logic [4:0] safe, input bit use_safe,
                            input bit preload, output int cycles);
    logic [15:0] l;
    int          placed;
    int          cand;
    wr_t         w;
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) begin
      model_board[i] = 0;
      w.addr = 10'(i);
      w.data = 32'd0;
      exp_q.push_back(w);
    end
    if (preload) model_board[7] = MINE;
    l      = (s == 16'h0000) ? 16'hACE1 : s;
    cycles = CELLS;
    placed = 0;
    while (placed < MINES) begin
      cand = int'(l[4:0]);
      l    = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      cycles++;
      if (cand >= CELLS || (use_safe && cand == int'(safe))) continue;
      cycles++;
      if (model_board[cand] == MINE) continue;
      model_board[cand] = MINE;
      w.addr = 10'(cand);
      w.data = 32'(MINE);
      exp_q.push_back(w);
      cycles++;
      placed++;
    end
  endtask

  // One full board run: model, start, per-cycle write scoreboard, final checks.
  task automatic applyStimulus(input logic [15:0] s, input logic [4:0] safe, input bit use_safe,
                               input bit preload, input bit pulse_busy);
    int  exp_cycles;
    int  cyc;
    int  wrong;
    wr_t w;
    buildModel(s, safe, use_safe, preload, exp_cycles);
    seed  = s;
`ifdef SAFE_FIRST_CELL_EN
    safe_cell = safe;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    seed  = ~s;
`ifdef SAFE_FIRST_CELL_EN
    safe_cell = safe + 5'd1;
`endif
    checkOutput("busy_after_start", busy, 1);
    checkOutput("done_low_after_start", done, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (mem_wEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write_addr", mem_addr, 10'h3FF);
        end else begin
          w = exp_q.pop_front();
          checkOutput("write_addr", mem_addr, w.addr);
          checkOutput("write_data", mem_dataIn, w.data);
        end
      end
      bd_en   = (preload && cyc == 25);
      bd_addr = 10'd7;
      bd_data = 32'(MINE);
      start   = (pulse_busy && (cyc == 5 || cyc == 25));
      step();
      cyc++;
    end
    bd_en = 1'b0;
    start = 1'b0;
    checkOutput("cycles_to_done", cyc, exp_cycles);
    checkOutput("writes_outstanding", exp_q.size(), 0);
    checkOutput("mines_at_done", mines, MINES);
    checkOutput("busy_at_done", busy, 0);
    checkOutput("wen_at_done", mem_wEn, 0);
    wrong = 0;
    for (int i = 0; i < CELLS; i++)
      if (ram[i] !== 32'(model_board[i])) wrong++;
    checkOutput("layout_mismatch_cells", wrong, 0);
    step();
    step();
    checkOutput("done_level_held", done, 1);
  endtask

  initial begin
    int cyc;
    reset   = 1'b1;
    start   = 1'b0;
    seed    = 16'h0000;
    bd_en   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
`ifdef SAFE_FIRST_CELL_EN
    safe_cell = '0;
`endif
    step();
    step();
    checkOutput("reset_wen", mem_wEn, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_datain", mem_dataIn, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_mines", mines, 0);
    reset = 1'b0;
    step();

    $display("[TB] seed 0001 twice");
    applyStimulus(16'h0001, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0001, 5'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] seed 0000 and ACE1");
    applyStimulus(16'h0000, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hACE1, 5'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] preloaded cell 7 with first candidate 7");
    applyStimulus(16'h0007, 5'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] start pulses while busy");
    applyStimulus(16'h5A5A, 5'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during a mine write");
    seed  = 16'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
    while (!(mem_wEn === 1'b1 && mines != 6'd0) && cyc < LIMIT) begin
      step();
      cyc++;
    end
    checkOutput("reached_second_write", cyc < LIMIT, 1);
    reset = 1'b1;
    step();
    checkOutput("midreset_wen", mem_wEn, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_mines", mines, 0);
    step();
    reset = 1'b0;
    step();
    step();
    checkOutput("after_reset_wen", mem_wEn, 0);
    checkOutput("after_reset_busy", busy, 0);

    $display("[TB] fresh run after aborted run");
    applyStimulus(16'hBEEF, 5'd0, 1'b0, 1'b0, 1'b0);

`ifdef SAFE_FIRST_CELL_EN
    $display("[TB] safe cell 12 over random seeds");
    for (int n = 0; n < 120; n++)
      applyStimulus(16'($urandom_range(65535)), 5'd12, 1'b1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
